// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the BCD 7-segment display controller.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package bcd_disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);
  localparam int unsigned BIN_W      = 12;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

  typedef enum logic [0:0] {
    StIdle,
    StConvert
  } state_e;

endpackage

// File: rtl/bin2bcd.sv
// Combinational 12-bit binary to 4-digit BCD converter (shift-and-add-3).
module bin2bcd
  import bcd_disp_pkg::*;
(
  input  logic [BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o
);

  logic [BCD_W+BIN_W-1:0] shift_v;

  always_comb begin
    shift_v = {{BCD_W{1'b0}}, bin_i};
    for (int i = 0; i < BIN_W; i++) begin
      // Correct every BCD column before the shift so no column passes 9.
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (shift_v[BIN_W + 4*d +: 4] >= 4'd5) begin
          shift_v[BIN_W + 4*d +: 4] = shift_v[BIN_W + 4*d +: 4] + 4'd3;
        end
      end
      shift_v = shift_v << 1;
    end
    bcd_o = shift_v[BCD_W+BIN_W-1:BIN_W];
  end

endmodule

// File: rtl/seg7_decode.sv
// BCD nibble to active-low 7-segment pattern; non-decimal nibbles show a dash.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Accepts a binary value, converts it to BCD in one cycle and scans the
// four digits onto a common-anode 7-segment display with leading-zero blanking.
module bcd_display_ctrl
  import bcd_disp_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  input  logic                  disp_en,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  busy
);

  localparam int unsigned TickW = $clog2(CLK_DIV);
  localparam logic [TickW-1:0] TickMax = TickW'(CLK_DIV - 1);

  state_e                  state_q, state_d;
  logic [BIN_W-1:0]        bin_q, bin_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [TickW-1:0]        tick_q, tick_d;
  logic [DIGIT_W-1:0]      digit_q, digit_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;

  logic [BCD_W-1:0]        bcd_conv;
  logic [3:0]              nibble;
  logic [6:0]              seg_dec;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    hi_zero;

  bin2bcd u_bin2bcd (
    .bin_i (bin_q),
    .bcd_o (bcd_conv)
  );

  assign nibble = bcd_q[{digit_q, 2'b00} +: 4];

  seg7_decode u_seg7_decode (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

  // Handshake FSM: one conversion cycle after every accept.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bin_d   = in_bin;
          state_d = StConvert;
        end
      end
      StConvert: begin
        busy    = 1'b1;
        bcd_d   = bcd_conv;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Free-running digit scan.
  always_comb begin
    tick_d  = tick_q + TickW'(1);
    digit_d = digit_q;
    if (tick_q == TickMax) begin
      tick_d  = '0;
      digit_d = digit_q + DIGIT_W'(1);
    end
  end

  // Digit k>0 is blank when every nibble from k upward is zero.
  always_comb begin
    lz_blank = '0;
    hi_zero  = blank_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      hi_zero     = hi_zero && (bcd_q[4*k +: 4] == 4'd0);
      lz_blank[k] = hi_zero;
    end
  end

  always_comb begin
    an_d  = ~(NUM_DIGITS'(1) << digit_q);
    seg_d = seg_dec;
    if (!disp_en || lz_blank[digit_q]) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      tick_q  <= '0;
      digit_q <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      tick_q  <= tick_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Bench for bcd_display_ctrl: decimal-arithmetic display model checked every
// cycle, plus directed scenarios with hand-computed segment patterns.
module tb_bcd_display_ctrl;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_bin;
  logic        disp_en;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bcd_display_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bin   (in_bin),
    .disp_en  (disp_en),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 100000");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  // Model: displayed decimal value, pending accept, and edges since reset.
  int         m_shown   = 0;
  int         m_pending = 0;
  bit         m_conv    = 1'b0;
  int         m_n       = 0;
  bit         m_init    = 1'b0;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        m_shown = 0;
        m_conv  = 1'b0;
        m_n     = 0;
      end else begin
        int  slot;
        bit  off;
        slot = (m_n / CLK_DIV) % 4;
        off  = !disp_en || (slot > 0 && blank_lz && m_shown < pow10(slot));
        exp_an  = off ? 4'hF : ~(4'b0001 << slot);
        exp_seg = off ? 7'h7F : seg_of((m_shown / pow10(slot)) % 10);
        if (m_conv) begin
          m_shown = m_pending;
          m_conv  = 1'b0;
        end else if (in_valid) begin
          m_pending = int'(in_bin);
          m_conv    = 1'b1;
        end
        m_n++;
      end
      m_init = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        check("an", int'(an), int'(exp_an));
        check("seg", int'(seg), int'(exp_seg));
        check("in_ready", int'(in_ready), int'(!m_conv));
        check("busy", int'(busy), int'(m_conv));
      end
    end
  end

  logic [6:0] cap_seg [4];
  int         cap_hits [4];
  int         cap_off;

  task automatic capture(input int n);
    for (int i = 0; i < 4; i++) begin
      cap_seg[i]  = 7'h7F;
      cap_hits[i] = 0;
    end
    cap_off = 0;
    repeat (n) begin
      @(negedge clk);
      case (an)
        4'b1110: begin cap_seg[0] = seg; cap_hits[0]++; end
        4'b1101: begin cap_seg[1] = seg; cap_hits[1]++; end
        4'b1011: begin cap_seg[2] = seg; cap_hits[2]++; end
        4'b0111: begin cap_seg[3] = seg; cap_hits[3]++; end
        4'b1111: cap_off++;
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds in_valid until a negedge sees in_ready; the following edge accepts.
  task automatic start_send(input logic [11:0] v);
    int k = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_bin   = v;
    while (!in_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("accept_timeout", k, k < 10 ? k : -1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bin = '0; disp_en = 1'b1; blank_lz = 1'b1;
    idle(3);
    check("rst_an", int'(an), 4'hF);
    check("rst_seg", int'(seg), 7'h7F);
    check("rst_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // Zero after reset: only digit 0 lights.
    idle(2);
    check("t1_an", int'(an), 4'b1110);
    check("t1_seg", int'(seg), 7'b1000000);
    capture(16);
    check("t1_off", cap_off, 12);

    // 1234 scanned across all four digits.
    start_send(12'd1234);
    check("t2_ready_low", int'(in_ready), 0);
    check("t2_busy_high", int'(busy), 1);
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_ready_back", int'(in_ready), 1);
    check("t2_busy_low", int'(busy), 0);
    idle(2);
    capture(16);
    check("t2_d0", int'(cap_seg[0]), 7'b0011001);
    check("t2_d1", int'(cap_seg[1]), 7'b0110000);
    check("t2_d2", int'(cap_seg[2]), 7'b0100100);
    check("t2_d3", int'(cap_seg[3]), 7'b1111001);
    for (int i = 0; i < 4; i++) check("t2_slot_len", cap_hits[i], 4);

    // 7 with and without leading-zero blanking.
    start_send(12'd7);
    in_valid = 1'b0;
    idle(3);
    capture(16);
    check("t3_d0", int'(cap_seg[0]), 7'b1111000);
    check("t3_off", cap_off, 12);
    blank_lz = 1'b0;
    idle(2);
    capture(16);
    check("t3_d1", int'(cap_seg[1]), 7'b1000000);
    check("t3_d2", int'(cap_seg[2]), 7'b1000000);
    check("t3_d3", int'(cap_seg[3]), 7'b1000000);
    check("t3_no_off", cap_off, 0);
    blank_lz = 1'b1;

    // 4095 then 100 held through the CONVERT cycle.
    start_send(12'd4095);
    in_bin = 12'd100;
    check("t4_ready_low", int'(in_ready), 0);
    @(negedge clk);
    check("t4_ready_back", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_busy_again", int'(busy), 1);
    idle(3);
    capture(16);
    check("t4_d0", int'(cap_seg[0]), 7'b1000000);
    check("t4_d1", int'(cap_seg[1]), 7'b1000000);
    check("t4_d2", int'(cap_seg[2]), 7'b1111001);
    check("t4_d3_blank", cap_hits[3], 0);
    check("t4_off", cap_off, 4);

    // Display disable mid-scan; phase continues underneath.
    idle(5);
    disp_en = 1'b0;
    @(negedge clk);
    check("t5_an_off", int'(an), 4'hF);
    check("t5_seg_off", int'(seg), 7'h7F);
    idle(5);
    disp_en = 1'b1;
    idle(20);

    // Reset during conversion of 999.
    start_send(12'd999);
    check("t6_busy", int'(busy), 1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_an", int'(an), 4'hF);
    check("t6_seg", int'(seg), 7'h7F);
    check("t6_ready", int'(in_ready), 1);
    check("t6_busy_low", int'(busy), 0);
    rst = 1'b0;
    idle(2);
    check("t6_an_zero", int'(an), 4'b1110);
    check("t6_seg_zero", int'(seg), 7'b1000000);
    capture(16);
    check("t6_d0", int'(cap_seg[0]), 7'b1000000);
    check("t6_off", cap_off, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
